// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal CMP: NIC register map and packet field layout.
// Packets use big-endian bit numbering [0:PKT_W-1].
package cardinal_pkg;

  localparam int PKT_W = 64;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  localparam int PKT_VC_BIT  = 0;
  localparam int PKT_DIR_BIT = 1;
  localparam int PKT_HOP_MSB = 2;
  localparam int PKT_HOP_LSB = 5;
  localparam int PKT_SRC_MSB = 6;
  localparam int PKT_SRC_LSB = 7;

endpackage

// File: rtl/node_nic_if.sv
// Processor-side register port and router-side packet port of one node NIC.
// The slave modport is the NIC; the master modport is the processor/router environment.
interface node_nic_if #(parameter int DATA_W = 64);

  logic [1:0]        addr;
  logic [0:DATA_W-1] d_in;
  logic [0:DATA_W-1] d_out;
  logic              nicEn;
  logic              nicWrEn;

  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;
  logic              net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

endinterface

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer: registered data plus full flag.
// A fill is accepted only while empty, a drain only while full.
module nic_chan_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill,
  input  logic [0:W-1] fill_data,
  input  logic         drain,
  output logic [0:W-1] data,
  output logic         full
);

  // Data is never cleared on drain, so a read of an empty buffer returns the last packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (fill && !full) begin
      data <= fill_data;
      full <= 1'b1;
    end else if (drain && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/node_nic.sv
// Cardinal CMP node NIC: bridges the processor's memory-mapped port and the ring router.
// Injection only happens on the ring phase that matches the packet's virtual channel.
module node_nic
  import cardinal_pkg::*;
#(
  parameter int DATA_W = PKT_W,
  parameter int VC_BIT = PKT_VC_BIT
) (
  input logic         clk,
  input logic         reset,
  node_nic_if.slave   bus
);

  logic              rd_en;
  logic              wr_en;
  logic              in_fill;
  logic              in_drain;
  logic              out_fill;
  logic              inject;
  logic [0:DATA_W-1] in_buf;
  logic [0:DATA_W-1] out_buf;
  logic              in_full;
  logic              out_full;

  assign rd_en    = bus.nicEn && !bus.nicWrEn;
  assign wr_en    = bus.nicEn && bus.nicWrEn;
  assign in_fill  = bus.net_si && !in_full;
  assign in_drain = rd_en && (bus.addr == NIC_ADDR_IN_BUF);
  assign out_fill = wr_en && (bus.addr == NIC_ADDR_OUT_BUF);
  assign inject   = out_full && bus.net_ro && (bus.net_polarity == out_buf[VC_BIT]);

  assign bus.net_ri = !in_full;

  nic_chan_buf #(.W(DATA_W)) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .fill      (in_fill),
    .fill_data (bus.net_di),
    .drain     (in_drain),
    .data      (in_buf),
    .full      (in_full)
  );

  // A write racing a drain sees out_full still set and is dropped inside the buffer.
  nic_chan_buf #(.W(DATA_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .fill      (out_fill),
    .fill_data (bus.d_in),
    .drain     (inject),
    .data      (out_buf),
    .full      (out_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.net_so <= 1'b0;
      bus.net_do <= '0;
    end else begin
      bus.net_so <= inject;
      if (inject) begin
        bus.net_do <= out_buf;
      end
    end
  end

  always_comb begin
    bus.d_out = '0;
    if (rd_en) begin
      case (bus.addr)
        NIC_ADDR_IN_BUF:   bus.d_out = in_buf;
        NIC_ADDR_IN_STAT:  bus.d_out = {{(DATA_W-1){1'b0}}, in_full};
        NIC_ADDR_OUT_BUF:  bus.d_out = out_buf;
        NIC_ADDR_OUT_STAT: bus.d_out = {{(DATA_W-1){1'b0}}, out_full};
        default:           bus.d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/node_nic.md
# node_nic

Network interface controller for one Cardinal CMP node. It connects the node processor's memory-mapped NIC port to the node's router port on the ring. There are two one-entry buffers:
- an input channel buffer, filled by the router and drained by processor reads;
- an output channel buffer, filled by processor writes and drained to the router.

Four instances sit inside `cardinal_cmp`, one between each processor and its ring router.

## Interface
Parameters:
- `DATA_W`, 64: packet and processor data width.
- `VC_BIT`, 0: packet bit carrying the virtual-channel (VC) tag. Bit numbering is big-endian `[0:63]`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  2  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `d_in`  in  `[0:63]`  processor write data.
- `d_out`  out  `[0:63]`  processor read data (combinational).
- `nicEn`  in  1  NIC access enable.
- `nicWrEn`  in  1  write enable; qualified by `nicEn`.
- `net_si`  in  1  router send-in: `net_di` is valid this cycle.
- `net_ri`  out  1  NIC ready to accept from the router.
- `net_di`  in  `[0:63]`  packet from the router.
- `net_so`  out  1  NIC send-out: `net_do` is valid this cycle.
- `net_ro`  in  1  router ready to accept from the NIC.
- `net_do`  out  `[0:63]`  packet to the router.
- `net_polarity`  in  1  router even/odd cycle phase.

## Operation
- **State.**
  - Input side: `in_buf[0:63]`, `in_full`.
  - Output side: `out_buf[0:63]`, `out_full`.
  - Output registers: `net_so` and `net_do`.
- **`net_ri`** = `!in_full` (combinational).
- **Input capture.** When `net_si && net_ri`: `in_buf <= net_di`, `in_full <= 1`. A `net_si` while `in_full` is a router protocol violation; the NIC ignores it and `in_buf` is unchanged.
- **Processor reads** (`nicEn && !nicWrEn`). `d_out` is selected by `addr`:
  - 00: `in_buf`. If `in_full`, `in_full <= 0` at the next edge. Reading 00 while empty returns stale data and changes no state.
  - 01: `{63'b0, in_full}`.
  - 10: `out_buf`. No state change.
  - 11: `{63'b0, out_full}`.
- **`d_out` when idle.** When `!nicEn` or `nicWrEn`, `d_out` = 0.
- **Processor writes** (`nicEn && nicWrEn`).
  - addr 10: if `!out_full`, then `out_buf <= d_in`, `out_full <= 1`. If `out_full` is already set, the write is dropped.
  - Writes to 00, 01 and 11 are ignored.
- **Injection.** At an edge where `out_full && net_ro && (net_polarity == out_buf[VC_BIT])`:
  - `net_so <= 1`, `net_do <= out_buf`, `out_full <= 0`.
  - Otherwise `net_so <= 0` and `net_do` holds its value.
- **Simultaneous events.**
  - Write to 10 in the same cycle the buffer drains: decided on pre-edge `out_full`, which is 1, so the write is dropped. Software must poll status 11 first.
  - Read of 00 plus an arriving packet cannot coincide, because `net_ri` = 0 while full.
  - Injection and a read of 10 may coincide; the read returns the departing packet.

## Timing
- **Reset values.** Asynchronous reset forces:
  - `in_full` = 0, `out_full` = 0;
  - `in_buf` = 0, `out_buf` = 0;
  - `net_so` = 0, `net_do` = 0.

  Resulting outputs: `net_ri` = 1; `d_out` = 0 unless a read is active. A packet in flight at reset is lost.
- **Router to processor.** `net_si` at edge N sets `in_full`; status 01 reads 1 in cycle N+1; reading 00 in cycle N+1 frees the buffer at edge N+2. `net_ri` returns high in cycle N+2.
- **Processor to router.** A write to 10 at edge N gives status 11 = 1 in cycle N+1. The earliest `net_so` pulse is at edge N+1 if `net_ro` and polarity match. `net_so` is high for exactly one cycle per packet.
- **Throughput.** At most one packet per two cycles per direction, since polarity alternates each cycle.

## Structure
- Package `cardinal_pkg`:
  - `NIC_ADDR_IN_BUF`/`IN_STAT`/`OUT_BUF`/`OUT_STAT` constants;
  - `PKT_W`;
  - packet field positions (`VC_BIT`, direction, hop count, source).
- Sub-module `nic_chan_buf`: one-entry buffer with registered data and full flag, and independent fill/drain strobes. It is instantiated twice, once per direction; the injection and polarity logic stays in `node_nic`.

## Test plan
1. Reset mid-traffic (`out_full` = 1, `in_full` = 1), assert `reset` asynchronously -> immediately `net_so` = 0, `net_ri` = 1, status 01/11 read 0.
2. Router delivers `net_di` = 64'hDEAD_BEEF_0000_0001 -> `net_ri` drops next cycle; status 01 = 1; read 00 returns the packet; `net_ri` = 1 two cycles after arrival.
3. Write 64'h8000_0000_0000_00AA (VC = 1) to 10 with `net_ro` = 1 -> `net_so` pulses only on the first edge with `net_polarity` = 1, `net_do` = written value, status 11 back to 0.
4. Second write to 10 while `out_full` with `net_ro` = 0 -> dropped; after `net_ro` rises, only the first packet appears on `net_do`.
5. Hold `net_si` high with back-to-back packets A, B while the processor never reads -> only A is captured; `in_buf` stays A.
6. Write to 10 at the same edge the buffer drains -> the write is dropped and status 11 = 0 afterwards.
